// File: rtl/console_byte_bridge_if.sv
// Signal bundle between the console byte bridge and its keyboard, UART and terminal neighbours.
// The bridge takes the master view; the surrounding system (or a bench) takes the slave view.
interface console_byte_bridge_if #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned TX_DEPTH_LOG2 = 4,
    parameter int unsigned RX_DEPTH_LOG2 = 4
);
    logic                    kb_valid;
    logic [DATA_WIDTH-1:0]   kb_data;
    logic                    echo_en;
    logic                    tx_start;
    logic [DATA_WIDTH-1:0]   tx_data;
    logic                    tx_busy;
    logic                    rx_ready;
    logic [DATA_WIDTH-1:0]   rx_data;
    logic                    term_valid;
    logic [DATA_WIDTH-1:0]   term_data;
    logic                    term_accept;
    logic                    clear_stats;
    logic [TX_DEPTH_LOG2:0]  tx_level;
    logic [RX_DEPTH_LOG2:0]  rx_level;
    logic [7:0]              tx_overflow_count;
    logic [7:0]              rx_overflow_count;

    modport master (
        input  kb_valid, kb_data, echo_en, tx_busy, rx_ready, rx_data, term_accept, clear_stats,
        output tx_start, tx_data, term_valid, term_data, tx_level, rx_level,
               tx_overflow_count, rx_overflow_count
    );

    modport slave (
        output kb_valid, kb_data, echo_en, tx_busy, rx_ready, rx_data, term_accept, clear_stats,
        input  tx_start, tx_data, term_valid, term_data, tx_level, rx_level,
               tx_overflow_count, rx_overflow_count
    );
endinterface

// File: rtl/console_byte_bridge.sv
// Buffered byte bridge: keyboard -> TX FIFO -> UART transmitter, and UART receiver plus
// optional local echo -> RX FIFO -> terminal, with saturating overflow statistics.
module console_byte_bridge #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned TX_DEPTH_LOG2 = 4,
    parameter int unsigned RX_DEPTH_LOG2 = 4,
    parameter int unsigned ACK_TIMEOUT   = 16
) (
    input logic                   clk,
    input logic                   rst,
    console_byte_bridge_if.master bus
);
    localparam int unsigned TxDepth = 2 ** TX_DEPTH_LOG2;
    localparam int unsigned RxDepth = 2 ** RX_DEPTH_LOG2;
    localparam int unsigned AckW    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [AckW-1:0]          AckLast = AckW'(ACK_TIMEOUT - 1);
    localparam logic [TX_DEPTH_LOG2:0]   TxFull  = (TX_DEPTH_LOG2 + 1)'(TxDepth);
    localparam logic [RX_DEPTH_LOG2:0]   RxFull  = (RX_DEPTH_LOG2 + 1)'(RxDepth);

    typedef enum logic [1:0] {StIdle, StWaitAck, StWaitDone} state_e;

    function automatic logic [7:0] sat_add(input logic [7:0] val, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, val} + {7'b0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    // TX FIFO and sequencer state
    logic [DATA_WIDTH-1:0]    tx_mem_q [TxDepth];
    logic [TX_DEPTH_LOG2-1:0] tx_wr_ptr_q, tx_rd_ptr_q;
    logic [TX_DEPTH_LOG2:0]   tx_level_q, tx_level_d;
    logic                     tx_push, tx_pop, tx_drop;
    state_e                   state_q, state_d;
    logic [AckW-1:0]          ack_cnt_q, ack_cnt_d;
    logic                     tx_start_q;
    logic [DATA_WIDTH-1:0]    tx_data_q;

    // RX FIFO, echo skid and statistics
    logic [DATA_WIDTH-1:0]    rx_mem_q [RxDepth];
    logic [RX_DEPTH_LOG2-1:0] rx_wr_ptr_q, rx_rd_ptr_q;
    logic [RX_DEPTH_LOG2:0]   rx_level_q, rx_level_d;
    logic                     rx_wr, rx_push, rx_pop, rx_full_drop, echo_req, echo_drop;
    logic [DATA_WIDTH-1:0]    rx_wr_data;
    logic                     skid_valid_q, skid_valid_d;
    logic [DATA_WIDTH-1:0]    skid_data_q, skid_data_d;
    logic [7:0]               tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d;
    logic [1:0]               rx_inc;

    always_comb begin
        state_d   = state_q;
        ack_cnt_d = ack_cnt_q;
        tx_pop    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (tx_level_q != '0 && !bus.tx_busy) begin
                    tx_pop    = 1'b1;
                    ack_cnt_d = '0;
                    state_d   = StWaitAck;
                end
            end
            StWaitAck: begin
                // A transmitter that never acknowledges must not stall the queue.
                if (bus.tx_busy) begin
                    state_d = StWaitDone;
                end else if (ack_cnt_q == AckLast) begin
                    state_d = StIdle;
                end else begin
                    ack_cnt_d = ack_cnt_q + 1'b1;
                end
            end
            StWaitDone: begin
                if (!bus.tx_busy) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign tx_push    = bus.kb_valid && (tx_level_q != TxFull || tx_pop);
    assign tx_drop    = bus.kb_valid && !tx_push;
    assign tx_level_d = tx_level_q + (TX_DEPTH_LOG2 + 1)'(tx_push)
                                   - (TX_DEPTH_LOG2 + 1)'(tx_pop);

    // Single RX write port: received byte first, then a parked echo byte, then a fresh echo.
    assign echo_req = bus.kb_valid && bus.echo_en;

    always_comb begin
        rx_wr        = 1'b0;
        rx_wr_data   = bus.rx_data;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        echo_drop    = 1'b0;
        if (bus.rx_ready) begin
            rx_wr = 1'b1;
        end else if (skid_valid_q) begin
            rx_wr        = 1'b1;
            rx_wr_data   = skid_data_q;
            skid_valid_d = 1'b0;
        end else if (echo_req) begin
            rx_wr      = 1'b1;
            rx_wr_data = bus.kb_data;
        end
        if (echo_req) begin
            if (skid_valid_q) begin
                echo_drop = 1'b1;
            end else if (bus.rx_ready) begin
                skid_valid_d = 1'b1;
                skid_data_d  = bus.kb_data;
            end
        end
    end

    assign rx_pop       = (rx_level_q != '0) && bus.term_accept;
    assign rx_push      = rx_wr && (rx_level_q != RxFull || rx_pop);
    assign rx_full_drop = rx_wr && !rx_push;
    assign rx_level_d   = rx_level_q + (RX_DEPTH_LOG2 + 1)'(rx_push)
                                     - (RX_DEPTH_LOG2 + 1)'(rx_pop);
    assign rx_inc       = {1'b0, echo_drop} + {1'b0, rx_full_drop};

    always_comb begin
        tx_ovf_d = bus.clear_stats ? 8'h00 : sat_add(tx_ovf_q, {1'b0, tx_drop});
        rx_ovf_d = bus.clear_stats ? 8'h00 : sat_add(rx_ovf_q, rx_inc);
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem_q[tx_wr_ptr_q] <= bus.kb_data;
        if (rx_push) rx_mem_q[rx_wr_ptr_q] <= rx_wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            ack_cnt_q    <= '0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= '0;
            tx_wr_ptr_q  <= '0;
            tx_rd_ptr_q  <= '0;
            tx_level_q   <= '0;
            rx_wr_ptr_q  <= '0;
            rx_rd_ptr_q  <= '0;
            rx_level_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            tx_ovf_q     <= '0;
            rx_ovf_q     <= '0;
        end else begin
            state_q      <= state_d;
            ack_cnt_q    <= ack_cnt_d;
            tx_start_q   <= tx_pop;
            if (tx_pop) tx_data_q <= tx_mem_q[tx_rd_ptr_q];
            if (tx_push) tx_wr_ptr_q <= tx_wr_ptr_q + 1'b1;
            if (tx_pop) tx_rd_ptr_q <= tx_rd_ptr_q + 1'b1;
            tx_level_q   <= tx_level_d;
            if (rx_push) rx_wr_ptr_q <= rx_wr_ptr_q + 1'b1;
            if (rx_pop) rx_rd_ptr_q <= rx_rd_ptr_q + 1'b1;
            rx_level_q   <= rx_level_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            tx_ovf_q     <= tx_ovf_d;
            rx_ovf_q     <= rx_ovf_d;
        end
    end

    assign bus.tx_start          = tx_start_q;
    assign bus.tx_data           = tx_data_q;
    assign bus.term_valid        = (rx_level_q != '0);
    assign bus.term_data         = rx_mem_q[rx_rd_ptr_q];
    assign bus.tx_level          = tx_level_q;
    assign bus.rx_level          = rx_level_q;
    assign bus.tx_overflow_count = tx_ovf_q;
    assign bus.rx_overflow_count = rx_ovf_q;
endmodule

// File: tb/tb_console_byte_bridge.sv
// Scoreboard bench for console_byte_bridge: expected TX/RX bytes are queued when driven and
// compared when the bridge emits tx_start or the terminal accepts a byte.
module tb_console_byte_bridge;
    localparam int BusyResp  = 0;
    localparam int BusyForce = 1;
    localparam int BusyNever = 2;

    logic clk;
    logic rst;

    console_byte_bridge_if #(.DATA_WIDTH(8), .TX_DEPTH_LOG2(4), .RX_DEPTH_LOG2(4)) bus ();

    console_byte_bridge #(
        .DATA_WIDTH   (8),
        .TX_DEPTH_LOG2(4),
        .RX_DEPTH_LOG2(4),
        .ACK_TIMEOUT  (16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int         errors = 0;
    int         checks = 0;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    int         busy_mode = BusyResp;
    logic       start_seen = 1'b0;
    int         start_cnt = 0;
    int         start_cyc_prev = 0;
    int         start_cyc_last = 0;
    int         cyc = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Transmitter model: busy rises the cycle after tx_start and stays high for 10 cycles.
    initial begin
        int hold;
        hold = 0;
        bus.tx_busy = 1'b0;
        forever begin
            tick();
            if (rst) begin
                bus.tx_busy = 1'b0;
                hold = 0;
            end else if (busy_mode == BusyForce) begin
                bus.tx_busy = 1'b1;
            end else if (busy_mode == BusyNever) begin
                bus.tx_busy = 1'b0;
            end else if (start_seen) begin
                bus.tx_busy = 1'b1;
                hold = 10;
            end else if (hold > 0) begin
                hold--;
                bus.tx_busy = (hold != 0);
            end else begin
                bus.tx_busy = 1'b0;
            end
        end
    end

    // Output monitor: pops the scoreboard on every transmit start and terminal accept.
    initial begin
        logic [7:0] exp;
        forever begin
            @(negedge clk);
            cyc++;
            start_seen = bus.tx_start;
            if (!rst) begin
                if (bus.tx_start) begin
                    start_cnt++;
                    start_cyc_prev = start_cyc_last;
                    start_cyc_last = cyc;
                    check_eq("tx_expected_start", 32'(tx_q.size() != 0), 32'd1);
                    if (tx_q.size() != 0) begin
                        exp = tx_q.pop_front();
                        check_eq("tx_data", 32'(bus.tx_data), 32'(exp));
                    end
                end
                if (bus.term_valid && bus.term_accept) begin
                    check_eq("rx_expected_pop", 32'(rx_q.size() != 0), 32'd1);
                    if (rx_q.size() != 0) begin
                        exp = rx_q.pop_front();
                        check_eq("term_data", 32'(bus.term_data), 32'(exp));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic kb_push(input logic [7:0] d);
        bus.kb_valid = 1'b1;
        bus.kb_data  = d;
        tick();
        bus.kb_valid = 1'b0;
    endtask

    task automatic wait_tx_drain(input int max_cyc);
        int n;
        n = 0;
        while ((tx_q.size() != 0 || bus.tx_level != 0) && n < max_cyc) begin
            tick();
            n++;
        end
        check_eq("tx_drain_in_time", 32'(n < max_cyc), 32'd1);
        repeat (15) tick();
    endtask

    task automatic drain_rx(input int max_cyc);
        int n;
        n = 0;
        bus.term_accept = 1'b1;
        while (bus.rx_level != 0 && n < max_cyc) begin
            tick();
            n++;
        end
        bus.term_accept = 1'b0;
        check_eq("rx_drain_in_time", 32'(n < max_cyc), 32'd1);
        check_eq("rx_q_empty", 32'(rx_q.size()), 32'd0);
    endtask

    task automatic pulse_clear();
        bus.clear_stats = 1'b1;
        tick();
        bus.clear_stats = 1'b0;
    endtask

    initial begin
        int base;
        int n;
        rst             = 1'b1;
        bus.kb_valid    = 1'b0;
        bus.kb_data     = '0;
        bus.echo_en     = 1'b0;
        bus.rx_ready    = 1'b0;
        bus.rx_data     = '0;
        bus.term_accept = 1'b0;
        bus.clear_stats = 1'b0;
        repeat (3) tick();

        check_eq("rst_tx_start", 32'(bus.tx_start), 32'd0);
        check_eq("rst_tx_data", 32'(bus.tx_data), 32'd0);
        check_eq("rst_term_valid", 32'(bus.term_valid), 32'd0);
        check_eq("rst_tx_level", 32'(bus.tx_level), 32'd0);
        check_eq("rst_rx_level", 32'(bus.rx_level), 32'd0);
        check_eq("rst_tx_ovf", 32'(bus.tx_overflow_count), 32'd0);
        check_eq("rst_rx_ovf", 32'(bus.rx_overflow_count), 32'd0);
        rst = 1'b0;
        repeat (2) tick();

        // Single byte: start pulse two cycles after kb_valid.
        tx_q.push_back(8'h41);
        kb_push(8'h41);
        check_eq("t1_level_one", 32'(bus.tx_level), 32'd1);
        check_eq("t1_no_early_start", 32'(bus.tx_start), 32'd0);
        tick();
        check_eq("t1_start", 32'(bus.tx_start), 32'd1);
        check_eq("t1_data", 32'(bus.tx_data), 32'h41);
        check_eq("t1_level_zero", 32'(bus.tx_level), 32'd0);
        tick();
        check_eq("t1_start_one_cycle", 32'(bus.tx_start), 32'd0);
        check_eq("t1_data_stable", 32'(bus.tx_data), 32'h41);
        repeat (15) tick();

        // Fill TX FIFO past full while transmitter is busy.
        busy_mode = BusyForce;
        tick();
        for (int i = 0; i < 20; i++) begin
            if (i < 16) tx_q.push_back(8'(8'h30 + i));
            kb_push(8'(8'h30 + i));
        end
        check_eq("t2_tx_full", 32'(bus.tx_level), 32'd16);
        check_eq("t2_tx_ovf", 32'(bus.tx_overflow_count), 32'd4);
        check_eq("t2_no_start_busy", 32'(bus.tx_start), 32'd0);
        busy_mode = BusyResp;
        wait_tx_drain(400);
        pulse_clear();
        check_eq("t2_clear_tx_ovf", 32'(bus.tx_overflow_count), 32'd0);

        // Transmitter never acknowledges: 16 cycles in WAIT_ACK, then the next byte.
        busy_mode = BusyNever;
        tick();
        base = start_cnt;
        tx_q.push_back(8'h55);
        tx_q.push_back(8'h56);
        kb_push(8'h55);
        kb_push(8'h56);
        n = 0;
        while (start_cnt < base + 2 && n < 60) begin
            tick();
            n++;
        end
        check_eq("t3_two_starts", 32'(start_cnt - base), 32'd2);
        check_eq("t3_timeout_spacing", 32'(start_cyc_last - start_cyc_prev), 32'd17);
        repeat (20) tick();
        busy_mode = BusyResp;
        tick();

        // Local echo colliding with a received byte; second echo lands on an occupied skid.
        bus.echo_en = 1'b1;
        check_eq("t4_term_idle", 32'(bus.term_valid), 32'd0);
        rx_q.push_back(8'h62);
        rx_q.push_back(8'h63);
        rx_q.push_back(8'h61);
        tx_q.push_back(8'h61);
        tx_q.push_back(8'h64);
        bus.rx_ready = 1'b1;
        bus.rx_data  = 8'h62;
        kb_push(8'h61);
        check_eq("t4_term_valid_next", 32'(bus.term_valid), 32'd1);
        check_eq("t4_head", 32'(bus.term_data), 32'h62);
        bus.rx_data = 8'h63;
        kb_push(8'h64);
        bus.rx_ready = 1'b0;
        check_eq("t4_echo_drop", 32'(bus.rx_overflow_count), 32'd1);
        tick();
        bus.echo_en = 1'b0;
        check_eq("t4_rx_level", 32'(bus.rx_level), 32'd3);
        drain_rx(20);
        wait_tx_drain(100);
        pulse_clear();
        check_eq("t4_clear_rx_ovf", 32'(bus.rx_overflow_count), 32'd0);

        // RX FIFO full behaviour and clear priority.
        for (int i = 0; i < 17; i++) begin
            if (i < 16) rx_q.push_back(8'(8'h80 + i));
            bus.rx_ready = 1'b1;
            bus.rx_data  = 8'(8'h80 + i);
            tick();
        end
        bus.rx_ready = 1'b0;
        check_eq("t5_rx_full", 32'(bus.rx_level), 32'd16);
        check_eq("t5_rx_ovf", 32'(bus.rx_overflow_count), 32'd1);
        rx_q.push_back(8'hA0);
        bus.rx_ready    = 1'b1;
        bus.rx_data     = 8'hA0;
        bus.term_accept = 1'b1;
        tick();
        bus.term_accept = 1'b0;
        check_eq("t5_full_swap_level", 32'(bus.rx_level), 32'd16);
        check_eq("t5_full_swap_ovf", 32'(bus.rx_overflow_count), 32'd1);
        check_eq("t5_new_head", 32'(bus.term_data), 32'h81);
        bus.rx_data     = 8'hA1;
        bus.clear_stats = 1'b1;
        tick();
        bus.clear_stats = 1'b0;
        check_eq("t5_clear_priority", 32'(bus.rx_overflow_count), 32'd0);
        bus.rx_data = 8'hA2;
        tick();
        bus.rx_ready = 1'b0;
        check_eq("t5_rx_ovf_again", 32'(bus.rx_overflow_count), 32'd1);
        drain_rx(40);

        // Reset while the sequencer waits for the transmitter with five bytes in each FIFO.
        tx_q.push_back(8'hB0);
        for (int i = 0; i < 6; i++) begin
            bus.rx_ready = (i < 5);
            bus.rx_data  = 8'(8'hC0 + i);
            kb_push(8'(8'hB0 + i));
        end
        bus.rx_ready = 1'b0;
        tick();
        check_eq("t6_tx_level", 32'(bus.tx_level), 32'd5);
        check_eq("t6_rx_level", 32'(bus.rx_level), 32'd5);
        check_eq("t6_busy", 32'(bus.tx_busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("t6_rst_tx_level", 32'(bus.tx_level), 32'd0);
        check_eq("t6_rst_rx_level", 32'(bus.rx_level), 32'd0);
        check_eq("t6_rst_rx_ovf", 32'(bus.rx_overflow_count), 32'd0);
        check_eq("t6_rst_tx_start", 32'(bus.tx_start), 32'd0);
        check_eq("t6_rst_term_valid", 32'(bus.term_valid), 32'd0);
        base = start_cnt;
        repeat (2) tick();
        rst = 1'b0;
        repeat (25) tick();
        check_eq("t6_no_spurious_start", 32'(start_cnt), 32'(base));
        check_eq("t6_tx_level_after", 32'(bus.tx_level), 32'd0);
        check_eq("tx_q_empty", 32'(tx_q.size()), 32'd0);
        check_eq("rx_q_left", 32'(rx_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/console_byte_bridge.md
Name: console_byte_bridge

Overview:
Buffered, parametrised byte bridge between the PS/2 ASCII source, the UART transmitter/receiver pair, and the terminal/VGA text consumer.
- Keyboard bytes go into a TX FIFO. A sequencer drains that FIFO into the UART transmitter using a start/busy handshake.
- Received UART bytes, plus optional local-echo keyboard bytes, go into an RX FIFO. The terminal consumer reads it through a valid/accept interface.
- Overflow statistics are kept for debug display on the segment displays.

Parameters:
DATA_WIDTH, 8, byte width on all data paths
TX_DEPTH_LOG2, 4, TX FIFO depth = 2**TX_DEPTH_LOG2 (16)
RX_DEPTH_LOG2, 4, RX FIFO depth = 2**RX_DEPTH_LOG2 (16)
ACK_TIMEOUT, 16, max cycles to wait for tx_busy to rise after tx_start

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
kb_valid  in  1  one-cycle pulse: kb_data is a new keyboard byte
kb_data  in  DATA_WIDTH  keyboard ASCII byte
echo_en  in  1  1 = keyboard bytes also pushed to RX path (local echo)
tx_start  out  1  one-cycle start pulse to UART transmitter
tx_data  out  DATA_WIDTH  byte to transmit; stable from tx_start until return to IDLE
tx_busy  in  1  transmitter busy
rx_ready  in  1  one-cycle pulse: rx_data valid
rx_data  in  DATA_WIDTH  received UART byte
term_valid  out  1  RX FIFO head valid
term_data  out  DATA_WIDTH  RX FIFO head (first-word-fall-through)
term_accept  in  1  consumer takes head when term_valid=1
clear_stats  in  1  synchronous clear of both overflow counters
tx_level  out  TX_DEPTH_LOG2+1  TX FIFO occupancy
rx_level  out  RX_DEPTH_LOG2+1  RX FIFO occupancy
tx_overflow_count  out  8  bytes dropped at TX FIFO, saturating
rx_overflow_count  out  8  bytes dropped at RX FIFO or echo skid, saturating

Behaviour:

Reset (async, rst=1):
- Both FIFOs empty; levels 0.
- tx_start=0, tx_data=0, term_valid=0, term_data don't-care.
- Counters 0; echo skid empty; sequencer in IDLE.

TX FIFO:
- Push on kb_valid.
- When full, the push is accepted only if a pop occurs in the same cycle. Otherwise the byte is dropped and tx_overflow_count increments, saturating at 255.
- Pointers wrap modulo depth; level distinguishes full from empty.

TX sequencer states:
- IDLE: if FIFO non-empty and tx_busy=0, pop head into tx_data and assert tx_start for exactly that one cycle, then go to WAIT_ACK.
- WAIT_ACK: count cycles.
  - tx_busy=1 -> WAIT_DONE.
  - Count reaches ACK_TIMEOUT with tx_busy still 0 -> IDLE. The byte counts as sent and is not retried.
- WAIT_DONE: tx_busy=0 -> IDLE.
- Minimum spacing between tx_start pulses is 3 cycles.

RX FIFO:
- Single write port; rx_ready has priority.
- kb_valid with echo_en=1:
  - If rx_ready=0 in that cycle and the skid is empty, the byte is written directly.
  - Otherwise it goes into a 1-entry echo skid, which is written on the first cycle with rx_ready=0.
  - kb_valid arriving while the skid is still occupied drops the echo byte and increments rx_overflow_count.
- Full-FIFO rule is the same as TX: a write is accepted only with a simultaneous pop, else dropped and rx_overflow_count increments.
- Both drop sources in one cycle increment rx_overflow_count by 2, saturating.

Terminal interface:
- term_valid = (rx_level != 0); term_data = head.
- Pop when term_valid & term_accept.
- A write to an empty FIFO is visible on term_valid the next cycle.

Statistics:
- clear_stats zeroes both counters. clear_stats has priority over a same-cycle increment.

Simultaneous events:
- Push and pop in the same cycle leave level unchanged.

Test Plan:
- Reset, then kb_valid with 0x41, tx_busy model rising 1 cycle after start and held 10 cycles -> tx_start single pulse with tx_data=0x41 2 cycles after kb_valid; tx_level 1->0.
- 20 kb_valid pulses (0x30..0x43) while tx_busy held 1 -> tx_level=16, tx_overflow_count=4. Release busy -> 0x30..0x3F sent in order.
- Transmitter that never asserts busy -> return to IDLE after 16 cycles in WAIT_ACK; next byte starts normally.
- echo_en=1, kb_valid 0x61 and rx_ready 0x62 in the same cycle -> RX order 0x62 then 0x61. A second kb_valid before the skid drains -> rx_overflow_count=1.
- 17 rx_ready bytes with term_accept=0 -> rx_level=16, rx_overflow_count=1. At full, rx_ready together with term_accept=1 -> write accepted, level stays 16.
- Assert rst mid-WAIT_DONE with both FIFOs holding 5 bytes -> all levels, counters and tx_start go to 0 immediately; after release, no spurious tx_start.
